// File: rtl/if_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package if_fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF   = 32'h8000_0000;
    localparam logic [31:0] NOP_INST       = 32'h0000_0013;
    localparam int          FIFO_DEPTH_DEF = 2;

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_RUN  = 1'b1;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return pc & ~32'd3;
    endfunction
endpackage

// File: rtl/if_fifo.sv
// Instruction buffer of {inst, pc} entries with a synchronous flush.
module if_fifo
    import if_fetch_pkg::*;
#(
    parameter int          DEPTH    = FIFO_DEPTH_DEF,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    localparam int         PW       = $clog2(DEPTH),
    localparam int         CW       = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_flush,
    input  logic          i_push,
    input  fetch_entry_t  i_data,
    input  logic          i_pop,
    output logic          o_valid,
    output fetch_entry_t  o_data,
    output logic [CW-1:0] o_count
);
    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A pop frees a slot in the same cycle, so push-while-full is legal then.
    assign w_pop  = i_pop && (r_cnt != '0);
    assign w_push = i_push && ((r_cnt != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '{inst: NOP_INST, pc: RESET_PC};
        end else if (i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= nxt(r_wr);
            end
            if (w_pop) r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;
endmodule

// File: rtl/if_fetch.sv
// Instruction fetch: issues word fetches, tags responses with their PC,
// buffers them for decode and squashes stale work on redirect.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
    parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        if_imem_req_valid,
    input  logic        imem_if_req_ready,
    output logic [31:0] if_imem_addr,
    input  logic        imem_if_rsp_valid,
    input  logic [31:0] imem_if_rsp_data,
    input  logic        ex_if_redirect,
    input  logic [31:0] ex_if_redirect_pc,
    output logic        if_id_valid,
    input  logic        id_if_ready,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc
);
    localparam int         PW      = $clog2(FIFO_DEPTH);
    localparam int         CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [0:0]    r_state;
    logic [31:0]   r_pc;
    logic [CW-1:0] r_outst;
    logic [CW-1:0] r_discard;
    logic [31:0]   r_pcq [FIFO_DEPTH];
    logic [PW-1:0] r_pcq_wr;
    logic [PW-1:0] r_pcq_rd;

    logic          w_acc;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_fifo_cnt;
    logic [CW:0]   w_inflight;
    fetch_entry_t  w_rsp_entry;
    fetch_entry_t  w_head;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Credit check counts buffered plus in-flight words, so a full buffer never overflows.
    assign w_inflight        = {1'b0, r_outst} + {1'b0, w_fifo_cnt};
    assign if_imem_req_valid = (r_state == ST_RUN) && !ex_if_redirect && (w_inflight < DEPTH_W);
    assign if_imem_addr      = r_pc;
    assign w_acc             = if_imem_req_valid && imem_if_req_ready;
    assign w_push            = imem_if_rsp_valid && !ex_if_redirect && (r_discard == '0);
    assign w_pop             = if_id_valid && id_if_ready;
    assign w_rsp_entry       = '{inst: imem_if_rsp_data, pc: r_pcq[r_pcq_rd]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_pc      <= RESET_PC;
            r_outst   <= '0;
            r_discard <= '0;
            r_pcq_wr  <= '0;
            r_pcq_rd  <= '0;
        end else begin
            r_state <= ST_RUN;
            if (ex_if_redirect)  r_pc <= align_pc(ex_if_redirect_pc);
            else if (w_acc)      r_pc <= r_pc + 32'd4;
            r_outst <= r_outst + CW'(w_acc) - CW'(imem_if_rsp_valid);
            // Every request still in flight after a redirect returns stale data.
            if (ex_if_redirect)
                r_discard <= r_outst - CW'(imem_if_rsp_valid);
            else if (imem_if_rsp_valid && (r_discard != '0))
                r_discard <= r_discard - CW'(1);
            if (w_acc)             r_pcq_wr <= nxt(r_pcq_wr);
            if (imem_if_rsp_valid) r_pcq_rd <= nxt(r_pcq_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) r_pcq[r_pcq_wr] <= r_pc;
    end

    if_fifo #(
        .DEPTH    (FIFO_DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (ex_if_redirect),
        .i_push  (w_push),
        .i_data  (w_rsp_entry),
        .i_pop   (w_pop),
        .o_valid (if_id_valid),
        .o_data  (w_head),
        .o_count (w_fifo_cnt)
    );

    assign if_id_inst = w_head.inst;
    assign if_id_pc   = w_head.pc;
endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus random traffic against a
// sequential-PC reference model and an in-order latency memory.
module tb_if_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_imem_req_valid;
    logic        imem_if_req_ready = 1'b0;
    logic [31:0] if_imem_addr;
    logic        imem_if_rsp_valid = 1'b0;
    logic [31:0] imem_if_rsp_data = '0;
    logic        ex_if_redirect = 1'b0;
    logic [31:0] ex_if_redirect_pc = '0;
    logic        if_id_valid;
    logic        id_if_ready = 1'b0;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;

    if_fetch dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .if_imem_req_valid (if_imem_req_valid),
        .imem_if_req_ready (imem_if_req_ready),
        .if_imem_addr      (if_imem_addr),
        .imem_if_rsp_valid (imem_if_rsp_valid),
        .imem_if_rsp_data  (imem_if_rsp_data),
        .ex_if_redirect    (ex_if_redirect),
        .ex_if_redirect_pc (ex_if_redirect_pc),
        .if_id_valid       (if_id_valid),
        .id_if_ready       (id_if_ready),
        .if_id_inst        (if_id_inst),
        .if_id_pc          (if_id_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc_n = 0;
    int          last_due = 0;
    int          lat_min = 1;
    int          lat_max = 1;
    int          acc_cnt = 0;
    int          pop_cnt = 0;
    mreq_t       mq[$];
    logic [31:0] req_log[$];
    logic [31:0] exp_fetch, exp_cons;
    bit          flush_chk = 0;
    bit          const_mem = 1;
    bit          arm37 = 0;
    bit          hit37 = 0;
    logic        o_req_v, o_id_v;
    logic [31:0] o_req_addr, o_id_pc, o_id_inst;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return const_mem ? 32'h0000_0093 : {a[15:0], ~a[31:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] logv(input int i);
        return (req_log.size() > i) ? req_log[i] : 32'hxxxx_xxxx;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        imem_if_req_ready = 0; imem_if_rsp_valid = 0; ex_if_redirect = 0; id_if_ready = 0;
        mq.delete(); req_log.delete();
        exp_fetch = 32'h8000_0000; exp_cons = 32'h8000_0000;
        flush_chk = 0; acc_cnt = 0; pop_cnt = 0;
        #1;
        chk("rst_req_valid", if_imem_req_valid, 0);
        chk("rst_id_valid", if_id_valid, 0);
        chk("rst_id_inst", if_id_inst, 32'h0000_0013);
        chk("rst_id_pc", if_id_pc, 32'h8000_0000);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // One clock: drive inputs after the falling edge, sample, check, advance model.
    task automatic cyc(input bit rd, input logic [31:0] rpc, input bit rdy, input bit idr);
        bit          rsp;
        logic [31:0] d;
        int          due;
        @(negedge clk);
        rsp = 0; d = '0;
        if (mq.size() > 0 && mq[0].due <= cyc_n) begin
            rsp = 1; d = memf(mq[0].addr); void'(mq.pop_front());
        end
        if (arm37 && rsp && if_id_valid) begin
            rd = 1; rpc = 32'h9000_0000; arm37 = 0; hit37 = 1;
        end
        imem_if_rsp_valid = rsp; imem_if_rsp_data = d;
        ex_if_redirect = rd; ex_if_redirect_pc = rpc;
        imem_if_req_ready = rdy; id_if_ready = idr;
        #1;
        o_req_v = if_imem_req_valid; o_req_addr = if_imem_addr;
        o_id_v = if_id_valid; o_id_pc = if_id_pc; o_id_inst = if_id_inst;
        if (flush_chk) chk("flush_after_redirect", o_id_v, 0);
        flush_chk = 0;
        if (rd) chk("req_during_redirect", o_req_v, 0);
        if (o_req_v) chk("req_addr", o_req_addr, exp_fetch);
        if (o_id_v) begin
            chk("id_pc", o_id_pc, exp_cons);
            chk("id_inst", o_id_inst, memf(o_id_pc));
        end
        if (rd) begin
            exp_fetch = rpc & ~32'd3; exp_cons = rpc & ~32'd3;
            flush_chk = 1; req_log.delete();
        end else begin
            if (o_req_v && rdy) begin
                acc_cnt++; req_log.push_back(o_req_addr);
                due = cyc_n + $urandom_range(lat_min, lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mq.push_back('{addr: o_req_addr, due: due});
                exp_fetch = exp_fetch + 32'd4;
            end
            if (o_id_v && idr) begin
                exp_cons = exp_cons + 32'd4; pop_cnt++;
            end
        end
        cyc_n++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        // First fetch and first decode-visible instruction timing
        const_mem = 1; lat_min = 1; lat_max = 1;
        do_reset();
        cyc(0, 0, 1, 1); chk("r33_c0_req_valid", o_req_v, 0);
        cyc(0, 0, 1, 1); chk("r33_c1_req_valid", o_req_v, 1);
        chk("r33_c1_addr", o_req_addr, 32'h8000_0000);
        cyc(0, 0, 1, 1); chk("r33_c2_id_valid", o_id_v, 0);
        cyc(0, 0, 1, 1); chk("r33_c3_id_valid", o_id_v, 1);
        chk("r33_c3_pc", o_id_pc, 32'h8000_0000);
        chk("r33_c3_inst", o_id_inst, 32'h0000_0093);
        repeat (8) cyc(0, 0, 1, 1);

        // Decode stalled: buffer fills, fetch stops, head holds
        const_mem = 0;
        do_reset();
        repeat (5) cyc(0, 0, 1, 0);
        chk("r34_held_valid_early", o_id_v, 1);
        chk("r34_held_pc_early", o_id_pc, 32'h8000_0000);
        repeat (7) cyc(0, 0, 1, 0);
        chk("r34_req_count", acc_cnt, 2);
        chk("r34_req0", logv(0), 32'h8000_0000);
        chk("r34_req1", logv(1), 32'h8000_0004);
        chk("r34_held_valid", o_id_v, 1);
        chk("r34_held_pc", o_id_pc, 32'h8000_0000);
        chk("r34_held_inst", o_id_inst, memf(32'h8000_0000));
        repeat (6) cyc(0, 0, 1, 1);
        chk("r34_drained", pop_cnt >= 2, 1);

        // Redirect with two fetches outstanding
        lat_min = 3; lat_max = 3;
        do_reset();
        repeat (3) cyc(0, 0, 1, 1);
        chk("r35_two_accepted", acc_cnt, 2);
        cyc(1, 32'h8000_0102, 1, 1);
        for (int i = 0; i < 20 && !o_id_v; i++) cyc(0, 0, 1, 1);
        chk("r35_first_req", logv(0), 32'h8000_0100);
        chk("r35_first_pc", o_id_pc, 32'h8000_0100);

        // Memory not ready: address holds, single acceptance
        lat_min = 1; lat_max = 1;
        do_reset();
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1);
            chk("r36_wait_valid", o_req_v, 1);
            chk("r36_wait_addr", o_req_addr, 32'h8000_0000);
        end
        chk("r36_no_accept", acc_cnt, 0);
        cyc(0, 0, 1, 1);
        chk("r36_one_accept", acc_cnt, 1);
        repeat (2) cyc(0, 0, 0, 1);
        chk("r36_still_one", acc_cnt, 1);
        repeat (4) cyc(0, 0, 1, 1);

        // Redirect colliding with a response and a pop
        do_reset();
        arm37 = 1; hit37 = 0;
        for (int i = 0; i < 20 && !hit37; i++) cyc(0, 0, 1, 1);
        chk("r37_collision_seen", hit37, 1);
        arm37 = 0;
        cyc(0, 0, 1, 1);
        chk("r37_valid_low", o_id_v, 0);
        for (int i = 0; i < 20 && !o_id_v; i++) cyc(0, 0, 1, 1);
        chk("r37_first_pc", o_id_pc, 32'h9000_0000);
        repeat (10) cyc(0, 0, 1, 1);

        // Fetch PC wraps at the top of the address space
        cyc(1, 32'hFFFF_FFFC, 1, 1);
        for (int i = 0; i < 20 && req_log.size() < 2; i++) cyc(0, 0, 1, 1);
        chk("r38_req0", logv(0), 32'hFFFF_FFFC);
        chk("r38_req1", logv(1), 32'h0000_0000);
        repeat (6) cyc(0, 0, 1, 1);

        // Redirect while still idle sets the first fetch address
        do_reset();
        cyc(1, 32'h4000_0013, 1, 1);
        cyc(0, 0, 1, 1);
        chk("idle_redirect_valid", o_req_v, 1);
        chk("idle_redirect_addr", o_req_addr, 32'h4000_0010);
        repeat (4) cyc(0, 0, 1, 1);

        // Random traffic: model checks every cycle
        lat_min = 1; lat_max = 4;
        do_reset();
        for (int i = 0; i < 400; i++)
            cyc($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0,
                $urandom_range(0, 3) != 0);
        chk("rand_progress", pop_cnt > 20, 1);

        // Reset in the middle of traffic abandons everything
        do_reset();
        lat_min = 1; lat_max = 1;
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 1);
        chk("midreset_first_addr", o_req_addr, 32'h8000_0000);
        repeat (8) cyc(0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
